// File: rtl/z80_mem_ctrl_if.sv
// Z80 bus / SRAM signal bundle for the memory controller.
// The slave modport is the controller; the master side is the CPU and SRAM.
interface z80_mem_ctrl_if;
  logic        mreq_n;
  logic        rd_n;
  logic        wr_n;
  logic        map_cycle;
  logic [15:0] phys_addr;
  logic [7:0]  cpu_data_in;
  logic [7:0]  cpu_data_out;
  logic        cpu_data_oe;
  logic        wait_n;
  logic [15:0] sram_addr;
  logic [7:0]  sram_dout;
  logic [7:0]  sram_din;
  logic        sram_doe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        busy;

  modport master (
    output mreq_n, rd_n, wr_n, map_cycle, phys_addr, cpu_data_in, sram_din,
    input  cpu_data_out, cpu_data_oe, wait_n, sram_addr, sram_dout,
           sram_doe, sram_ce_n, sram_oe_n, sram_we_n, busy
  );

  modport slave (
    input  mreq_n, rd_n, wr_n, map_cycle, phys_addr, cpu_data_in, sram_din,
    output cpu_data_out, cpu_data_oe, wait_n, sram_addr, sram_dout,
           sram_doe, sram_ce_n, sram_oe_n, sram_we_n, busy
  );
endinterface

// File: rtl/z80_mem_ctrl.sv
// Z80 to asynchronous SRAM bridge: synchronizes the bus strobes, stretches the
// CPU cycle with WAIT and sequences CE/OE/WE with a fixed strobe length.
//
// state  | meaning
// IDLE   | no access; waiting for a synchronized read or write
// SETUP  | address/data latched, CE asserted, write data driven
// ACCESS | OE or WE strobe for WAIT_CYCLES clocks
// DONE   | strobe released, read data captured, WAIT released
// HOLD   | SRAM deselected; read data held until the CPU ends the cycle
module z80_mem_ctrl #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  z80_mem_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_DONE   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [1:0]  r_mreq_sync;
  logic [1:0]  r_rd_sync;
  logic [1:0]  r_wr_sync;
  logic [3:0]  r_cnt;
  logic        r_is_wr;
  logic        r_map;
  logic [15:0] r_sram_addr;
  logic [7:0]  r_sram_dout;
  logic [7:0]  r_cpu_data_out;
  logic        r_cpu_data_oe;
  logic        r_wait_n;
  logic        r_sram_doe;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_busy;

  logic        w_s_mreq_n;
  logic        w_s_rd_n;
  logic        w_s_wr_n;
  logic        w_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mreq_sync <= 2'b11;
      r_rd_sync   <= 2'b11;
      r_wr_sync   <= 2'b11;
    end else begin
      r_mreq_sync <= {r_mreq_sync[0], bus.mreq_n};
      r_rd_sync   <= {r_rd_sync[0], bus.rd_n};
      r_wr_sync   <= {r_wr_sync[0], bus.wr_n};
    end
  end

  assign w_s_mreq_n = r_mreq_sync[1];
  assign w_s_rd_n   = r_rd_sync[1];
  assign w_s_wr_n   = r_wr_sync[1];
  // refresh (both high) and the illegal both-low combination never start a cycle
  assign w_start    = !w_s_mreq_n && (w_s_rd_n ^ w_s_wr_n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_is_wr        <= 1'b0;
      r_map          <= 1'b0;
      r_sram_addr    <= 16'h0000;
      r_sram_dout    <= 8'h00;
      r_cpu_data_out <= 8'h00;
      r_cpu_data_oe  <= 1'b0;
      r_wait_n       <= 1'b1;
      r_sram_doe     <= 1'b0;
      r_ce_n         <= 1'b1;
      r_oe_n         <= 1'b1;
      r_we_n         <= 1'b1;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_SETUP;
            r_sram_addr <= bus.phys_addr;
            r_sram_dout <= bus.cpu_data_in;
            r_is_wr     <= !w_s_wr_n;
            r_map       <= bus.map_cycle;
            r_wait_n    <= 1'b0;
            r_ce_n      <= bus.map_cycle;
            r_sram_doe  <= !w_s_wr_n;
            r_busy      <= 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
          r_cnt   <= 4'd0;
          r_oe_n  <= r_is_wr || r_map;
          r_we_n  <= !r_is_wr || r_map;
        end
        S_ACCESS: begin
          if (r_cnt == LP_LAST) begin
            r_state  <= S_DONE;
            r_oe_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_wait_n <= 1'b1;
            if (!r_is_wr) begin
              r_cpu_data_out <= r_map ? 8'hFF : bus.sram_din;
              r_cpu_data_oe  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state       <= S_HOLD;
          r_ce_n        <= 1'b1;
          r_sram_doe    <= 1'b0;
          r_cpu_data_oe <= !r_is_wr && !w_s_rd_n;
        end
        S_HOLD: begin
          if (w_s_mreq_n) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_cpu_data_oe <= 1'b0;
          end else begin
            r_cpu_data_oe <= !r_is_wr && !w_s_rd_n;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sram_addr    = r_sram_addr;
  assign bus.sram_dout    = r_sram_dout;
  assign bus.sram_doe     = r_sram_doe;
  assign bus.sram_ce_n    = r_ce_n;
  assign bus.sram_oe_n    = r_oe_n;
  assign bus.sram_we_n    = r_we_n;
  assign bus.cpu_data_out = r_cpu_data_out;
  assign bus.cpu_data_oe  = r_cpu_data_oe;
  assign bus.wait_n       = r_wait_n;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_z80_mem_ctrl.sv
// Bench for z80_mem_ctrl: two instances (strobe 2 and 15) share one Z80 bus,
// each with its own SRAM model; results are compared to a cycle-count model.
module tb_z80_mem_ctrl;
  localparam int W_A = 2;
  localparam int W_B = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        mreq_n, rd_n, wr_n, map_cycle;
  logic [15:0] phys_addr;
  logic [7:0]  cpu_data_in;

  z80_mem_ctrl_if ifa ();
  z80_mem_ctrl_if ifb ();

  z80_mem_ctrl #(.WAIT_CYCLES(W_A)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  z80_mem_ctrl #(.WAIT_CYCLES(W_B)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  assign ifa.mreq_n = mreq_n;       assign ifb.mreq_n = mreq_n;
  assign ifa.rd_n = rd_n;           assign ifb.rd_n = rd_n;
  assign ifa.wr_n = wr_n;           assign ifb.wr_n = wr_n;
  assign ifa.map_cycle = map_cycle; assign ifb.map_cycle = map_cycle;
  assign ifa.phys_addr = phys_addr; assign ifb.phys_addr = phys_addr;
  assign ifa.cpu_data_in = cpu_data_in;
  assign ifb.cpu_data_in = cpu_data_in;

  logic [7:0] mem_a [65536];
  logic [7:0] mem_b [65536];
  logic [7:0] ref_mem [65536];

  assign ifa.sram_din = mem_a[ifa.sram_addr];
  assign ifb.sram_din = mem_b[ifb.sram_addr];

  // SRAM commits on the rising edge of WE
  always @(posedge ifa.sram_we_n)
    if (rst_n && ifa.sram_doe && !ifa.sram_ce_n) mem_a[ifa.sram_addr] = ifa.sram_dout;
  always @(posedge ifb.sram_we_n)
    if (rst_n && ifb.sram_doe && !ifb.sram_ce_n) mem_b[ifb.sram_addr] = ifb.sram_dout;

  logic [1:0]  v_wait, v_ce, v_oe, v_we, v_doe, v_cdoe, v_busy;
  logic [15:0] v_addr [2];
  logic [7:0]  v_sdo [2];
  logic [7:0]  v_cdo [2];
  assign v_wait = {ifb.wait_n, ifa.wait_n};
  assign v_ce   = {ifb.sram_ce_n, ifa.sram_ce_n};
  assign v_oe   = {ifb.sram_oe_n, ifa.sram_oe_n};
  assign v_we   = {ifb.sram_we_n, ifa.sram_we_n};
  assign v_doe  = {ifb.sram_doe, ifa.sram_doe};
  assign v_cdoe = {ifb.cpu_data_oe, ifa.cpu_data_oe};
  assign v_busy = {ifb.busy, ifa.busy};
  assign v_addr[0] = ifa.sram_addr;    assign v_addr[1] = ifb.sram_addr;
  assign v_sdo[0]  = ifa.sram_dout;    assign v_sdo[1]  = ifb.sram_dout;
  assign v_cdo[0]  = ifa.cpu_data_out; assign v_cdo[1]  = ifb.cpu_data_out;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Cycle counts that follow directly from the strobe length W:
  // wait low = setup + strobe, CE covers setup..done, write data covers setup..done.
  function automatic int exp_cnt(input int sel, input int w, input bit wr, input bit map);
    case (sel)
      0: return 1 + w;
      1: return map ? 0 : w + 2;
      2: return (!wr && !map) ? w : 0;
      3: return (wr && !map) ? w : 0;
      default: return wr ? w + 2 : 0;
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input int i);
    logic [15:0] a;
    a = 16'(i);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic bus_idle();
    mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic run_cycle(input bit wr, input bit map, input logic [15:0] addr,
                           input logic [7:0] wd, input int rel,
                           input int ea_wait, input int ea_ce, input int ea_oe,
                           input int ea_we, input int ea_doe,
                           input logic [7:0] e_data, input string tag);
    int cw[2], cce[2], coe[2], cwe[2], cdoe[2], first[2], viol[2];
    int ew[2], ece[2], eoe[2], ewe[2], edoe[2];
    bit seen[2];
    logic [7:0] dcap[2];
    ew[0] = ea_wait; ece[0] = ea_ce; eoe[0] = ea_oe; ewe[0] = ea_we; edoe[0] = ea_doe;
    ew[1] = exp_cnt(0, W_B, wr, map); ece[1] = exp_cnt(1, W_B, wr, map);
    eoe[1] = exp_cnt(2, W_B, wr, map); ewe[1] = exp_cnt(3, W_B, wr, map);
    edoe[1] = exp_cnt(4, W_B, wr, map);
    for (int j = 0; j < 2; j++) begin
      cw[j] = 0; cce[j] = 0; coe[j] = 0; cwe[j] = 0; cdoe[j] = 0;
      first[j] = -1; viol[j] = 0; seen[j] = 1'b0; dcap[j] = 8'h00;
    end
    @(negedge clk);
    phys_addr = addr; cpu_data_in = wd; map_cycle = map;
    rd_n = wr; wr_n = !wr; mreq_n = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 2; j++) begin
        if (!v_wait[j]) begin cw[j]++; if (first[j] < 0) first[j] = k; end
        if (!v_ce[j]) cce[j]++;
        if (!v_oe[j]) coe[j]++;
        if (!v_we[j]) cwe[j]++;
        if (v_doe[j]) cdoe[j]++;
        if ((!v_oe[j] && !v_we[j]) || (!v_we[j] && !v_doe[j])) viol[j]++;
        if (v_cdoe[j]) begin seen[j] = 1'b1; dcap[j] = v_cdo[j]; end
      end
      if (k == rel) bus_idle();
    end
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 2; j++) begin
      string p;
      p = $sformatf("%s.%s", tag, j == 0 ? "a" : "b");
      chk({p, ".wait_start"}, first[j], 3);
      chk({p, ".wait_len"}, cw[j], ew[j]);
      chk({p, ".ce_len"}, cce[j], ece[j]);
      chk({p, ".oe_len"}, coe[j], eoe[j]);
      chk({p, ".we_len"}, cwe[j], ewe[j]);
      chk({p, ".doe_len"}, cdoe[j], edoe[j]);
      chk({p, ".strobe_rule"}, viol[j], 0);
      chk({p, ".addr"}, v_addr[j], addr);
      if (wr) begin
        chk({p, ".wdata"}, v_sdo[j], wd);
        chk({p, ".no_cpu_oe"}, seen[j], 0);
      end else begin
        chk({p, ".cpu_oe"}, seen[j], 1);
        chk({p, ".rdata"}, dcap[j], e_data);
      end
      chk({p, ".release"}, {v_busy[j], v_cdoe[j], v_wait[j]}, 3'b001);
    end
    if (wr && !map) ref_mem[addr] = wd;
  endtask

  typedef struct {
    bit          wr;
    bit          map;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          rel;
    int          e_wait, e_ce, e_oe, e_we, e_doe;
    logic [7:0]  e_data;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int bad;
    logic [15:0] last_wr;
    rst_n = 1'b0;
    bus_idle();
    map_cycle = 1'b0; phys_addr = 16'h0; cpu_data_in = 8'h0;
    #1;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = init_byte(i); mem_b[i] = init_byte(i); ref_mem[i] = init_byte(i);
    end

    //          wr map addr      wdata rel wait ce oe we doe data
    vecs[0]  = '{1, 0, 16'h4001, 8'hA7, 0, 3, 4, 0, 2, 4, 8'h00};
    vecs[1]  = '{0, 0, 16'h4001, 8'h00, 0, 3, 4, 2, 0, 0, 8'hA7};
    vecs[2]  = '{0, 0, 16'h12AB, 8'h00, 0, 3, 4, 2, 0, 0, 8'h12 ^ 8'hAB};
    vecs[3]  = '{1, 0, 16'h12AB, 8'h5C, 0, 3, 4, 0, 2, 4, 8'h00};
    vecs[4]  = '{0, 0, 16'h12AB, 8'h00, 4, 3, 4, 2, 0, 0, 8'h5C};
    vecs[5]  = '{1, 1, 16'h0003, 8'h11, 0, 3, 0, 0, 0, 4, 8'h00};
    vecs[6]  = '{0, 0, 16'h0003, 8'h00, 0, 3, 4, 2, 0, 0, 8'h03};
    vecs[7]  = '{0, 1, 16'h0005, 8'h00, 0, 3, 0, 0, 0, 0, 8'hFF};
    vecs[8]  = '{0, 0, 16'hFFFF, 8'h00, 0, 3, 4, 2, 0, 0, 8'h00};
    vecs[9]  = '{0, 0, 16'h0100, 8'h00, 0, 3, 4, 2, 0, 0, 8'h01};
    vecs[10] = '{1, 0, 16'hFFFF, 8'hE4, 3, 3, 4, 0, 2, 4, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state.a", {v_wait[0], v_ce[0], v_oe[0], v_we[0], v_doe[0], v_cdoe[0], v_busy[0],
                          v_addr[0], v_sdo[0], v_cdo[0]}, {7'b1111000, 32'h0});
    chk("reset_state.b", {v_wait[1], v_ce[1], v_oe[1], v_we[1], v_doe[1], v_cdoe[1], v_busy[1],
                          v_addr[1], v_sdo[1], v_cdo[1]}, {7'b1111000, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 11; i++)
      run_cycle(vecs[i].wr, vecs[i].map, vecs[i].addr, vecs[i].wdata, vecs[i].rel,
                vecs[i].e_wait, vecs[i].e_ce, vecs[i].e_oe, vecs[i].e_we, vecs[i].e_doe,
                vecs[i].e_data, $sformatf("vec%0d", i));

    // refresh, then the illegal both-strobes-low combination
    for (int m = 0; m < 2; m++) begin
      bad = 0;
      @(negedge clk);
      phys_addr = 16'h5555; mreq_n = 1'b0; rd_n = (m == 1) ? 1'b0 : 1'b1; wr_n = rd_n;
      repeat (10) begin
        @(posedge clk); #1;
        if (v_busy != 2'b00 || v_wait != 2'b11 || v_ce != 2'b11 || v_oe != 2'b11 ||
            v_we != 2'b11) bad++;
      end
      bus_idle();
      chk(m == 0 ? "refresh_ignored" : "illegal_ignored", bad, 0);
      repeat (3) @(posedge clk);
    end

    // reset in the middle of a write strobe, with mreq still low afterwards
    @(negedge clk);
    phys_addr = 16'h2222; cpu_data_in = 8'h99; map_cycle = 1'b0;
    wr_n = 1'b0; rd_n = 1'b1; mreq_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midwrite_we_low", v_we, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("reset_abort.a", {v_we[0], v_doe[0], v_wait[0], v_busy[0], v_ce[0], v_oe[0]}, 6'b101011);
    chk("reset_abort.b", {v_we[1], v_doe[1], v_wait[1], v_busy[1], v_ce[1], v_oe[1]}, 6'b101011);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      chk($sformatf("resync_edge%0d", e), v_busy, (e == 3) ? 2'b11 : 2'b00);
    end
    repeat (22) @(posedge clk);
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_write_done", v_busy, 2'b00);
    ref_mem[16'h2222] = 8'h99;
    run_cycle(0, 0, 16'h2222, 8'h00, 0, exp_cnt(0, W_A, 0, 0), exp_cnt(1, W_A, 0, 0),
              exp_cnt(2, W_A, 0, 0), exp_cnt(3, W_A, 0, 0), exp_cnt(4, W_A, 0, 0),
              ref_mem[16'h2222], "after_reset");

    last_wr = 16'h4001;
    for (int t = 0; t < 40; t++) begin
      bit wr, map;
      logic [15:0] addr;
      logic [7:0] wd;
      int rel;
      wr   = 1'($urandom_range(0, 1));
      map  = ($urandom_range(0, 5) == 0);
      addr = ($urandom_range(0, 1) == 1) ? last_wr : 16'($urandom);
      wd   = 8'($urandom);
      rel  = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(3, 8));
      if (wr && !map) last_wr = addr;
      run_cycle(wr, map, addr, wd, rel, exp_cnt(0, W_A, wr, map), exp_cnt(1, W_A, wr, map),
                exp_cnt(2, W_A, wr, map), exp_cnt(3, W_A, wr, map), exp_cnt(4, W_A, wr, map),
                map ? 8'hFF : ref_mem[addr], $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/z80_mem_ctrl.md
Z80_MEM_CTRL -- requirements
Module: z80_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: SRAM strobe length in clk cycles, legal range 1..15.
REQ-002 clk  input  1  single system clock, all logic on rising edge, clk >= 4x Z80 CPU clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mreq_n, rd_n, wr_n  input  1 each  raw Z80 bus strobes, asynchronous to clk.
REQ-005 map_cycle  input  1  high when the current virtual page is 0 (MMU page-table write); no SRAM access is made.
REQ-006 phys_addr  input  16  physical address from the MMU, stable while mreq_n is low.
REQ-007 cpu_data_in  input  8  Z80 write data; cpu_data_out  output  8  read data to Z80; cpu_data_oe  output  1  drive enable for cpu_data_out.
REQ-008 wait_n  output  1  Z80 WAIT, low stretches the bus cycle.
REQ-009 sram_addr  output  16; sram_dout  output  8; sram_din  input  8; sram_doe  output  1  SRAM data bus drive enable.
REQ-010 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SRAM strobes, active-low.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 mreq_n, rd_n and wr_n each pass through a two-flop synchronizer; the FSM uses only synchronized copies (s_mreq_n, s_rd_n, s_wr_n).
REQ-013 FSM states: IDLE, SETUP, ACCESS, DONE, HOLD; all state and outputs registered.
REQ-014 IDLE->SETUP when s_mreq_n=0 and exactly one of s_rd_n or s_wr_n is 0; otherwise remain in IDLE.
REQ-015 Refresh (s_mreq_n=0, s_rd_n=s_wr_n=1) and illegal s_rd_n=s_wr_n=0 cause no access, no wait_n assertion, and no state change.
REQ-016 On IDLE->SETUP, latch phys_addr into sram_addr, cpu_data_in into sram_dout, direction (read/write) and map_cycle; drive wait_n=0.
REQ-017 SETUP (1 cycle): sram_ce_n=0 unless latched map_cycle=1; for a write, sram_doe=1; next state ACCESS.
REQ-018 ACCESS: count WAIT_CYCLES cycles; read drives sram_oe_n=0, write drives sram_we_n=0; map cycle drives no strobe; wait_n stays 0; on final count -> DONE.
REQ-019 Counter width is 4 bits, clears on ACCESS entry, never wraps.
REQ-020 DONE (1 cycle): sram_oe_n=1, sram_we_n=1, sram_ce_n stays 0 except on map cycle; read captures sram_din into cpu_data_out at ACCESS->DONE edge; sram_doe stays 1 for writes (data hold); wait_n=1; next HOLD.
REQ-021 HOLD: sram_ce_n=1, sram_doe=0; cpu_data_oe=1 for a read while s_rd_n=0; map cycle returns cpu_data_out=8'hFF; -> IDLE when s_mreq_n=1.
REQ-022 cpu_data_oe is 0 in every state except DONE and HOLD of a read, and in HOLD it drops the cycle after s_rd_n returns high.
REQ-023 mreq_n deasserting before DONE does not truncate the SRAM strobe: sequence completes, HOLD exits on the next cycle.
REQ-024 sram_oe_n and sram_we_n are never both 0; sram_we_n is never 0 while sram_doe=0.
REQ-025 Total wait_n low time = 1 + WAIT_CYCLES clk cycles, starting 3 cycles after the raw mreq_n/strobe fall.

Reset
REQ-026 rst_n=0 immediately forces state IDLE, sram_ce_n=sram_oe_n=sram_we_n=1, wait_n=1, sram_doe=0, cpu_data_oe=0, busy=0, sram_addr=0, sram_dout=0, cpu_data_out=0, counter=0, synchronizer flops=1.
REQ-027 Reset asserted mid-access aborts the access with no strobe glitch; after release, a pending low mreq_n starts a fresh access only after resynchronization.

Verification
REQ-028 Read, WAIT_CYCLES=2: phys_addr=16'h12AB, sram_din=8'h5C, mreq_n/rd_n low -> sram_oe_n low 2 cycles, wait_n low 3 cycles, cpu_data_out=8'h5C with cpu_data_oe=1 until rd_n high.
REQ-029 Write: phys_addr=16'h4001, cpu_data_in=8'hA7, wr_n low -> sram_addr=16'h4001, sram_dout=8'hA7, sram_we_n low 2 cycles inside sram_doe high window, sram_doe drops 1 cycle after sram_we_n rises.
REQ-030 Map cycle: map_cycle=1, wr_n low -> no sram_ce_n/oe_n/we_n activity, wait_n still low 3 cycles, busy returns 0 after mreq_n high.
REQ-031 Refresh and illegal: mreq_n low with rd_n=wr_n=1, then with rd_n=wr_n=0 -> stays IDLE, wait_n=1, all SRAM strobes high.
REQ-032 Reset mid-ACCESS of a write -> sram_we_n=1, sram_doe=0, wait_n=1 asynchronously; next legal cycle completes normally.
REQ-033 WAIT_CYCLES=15 back-to-back reads to 16'hFFFF then 16'h0100 -> each strobe exactly 15 cycles, counter never wraps, correct data both reads.
